// File: rtl/frame_buf_mem_initiator_pkg.sv
`default_nettype none
// ============================================================================
// frame_buf_mem_initiator_pkg : shared states, enable levels, timing defaults
// Rev 1.0
// ============================================================================
package frame_buf_mem_initiator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD   = 3'd2,
        ST_CAP  = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

    localparam logic ASSERT_L   = 1'b0;
    localparam logic DEASSERT_L = 1'b1;

    localparam int DEF_WR_HOLD  = 3;
    localparam int DEF_RD_HOLD  = 3;
    localparam int DEF_IDLE_GAP = 2;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_buf_mem_initiator_addr_ctr.sv
`default_nettype none
// ============================================================================
// frame_addr_ctr : frame address pointer with wrap and one-cycle wrap pulse
// Rev 1.0
// ============================================================================
module frame_addr_ctr #(
    parameter int                    ADDR_WIDTH   = 29,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = ADDR_WIDTH'(1),
    parameter int                    FRAME_PIXELS = 307200
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  wrap_pulse
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = BASE_ADDR + ADDR_WIDTH'(FRAME_PIXELS - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            addr       <= BASE_ADDR;
            wrap_pulse <= 1'b0;
        end else begin
            wrap_pulse <= 1'b0;
            if (inc) begin
                if (addr == LAST_ADDR) begin
                    addr       <= BASE_ADDR;
                    wrap_pulse <= 1'b1;
                end else begin
                    addr <= addr + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/frame_buf_mem_initiator.sv
`default_nettype none
// ============================================================================
// frame_buf_mem_initiator : pixel write / scan-out read requester for the
// active-low, address-change-triggered frame-buffer memory port.  Rev 1.0
// ============================================================================
module frame_buf_mem_initiator
    import frame_buf_mem_initiator_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 29,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = ADDR_WIDTH'(1),
    parameter int                    FRAME_PIXELS = 307200,
    parameter int                    WR_HOLD      = DEF_WR_HOLD,
    parameter int                    RD_HOLD      = DEF_RD_HOLD,
    parameter int                    IDLE_GAP     = DEF_IDLE_GAP
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  rd_req,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  wr_frame_done,
    output logic                  rd_frame_done,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_en_n,
    output logic                  rd_en_n,
    input  logic [DATA_WIDTH-1:0] rd_data
);

    localparam int CNT_W = $clog2(max3(WR_HOLD, RD_HOLD, IDLE_GAP) + 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_next;
    logic                  r_last_wr;
    logic                  w_last_wr_next;
    logic                  w_wr_en_n_next;
    logic                  w_rd_en_n_next;
    logic                  w_in_ready_next;
    logic                  w_out_valid_next;
    logic [DATA_WIDTH-1:0] w_wr_data_next;
    logic [DATA_WIDTH-1:0] w_out_data_next;
    logic                  w_wr_inc;
    logic                  w_rd_inc;

    frame_addr_ctr #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .BASE_ADDR    (BASE_ADDR),
        .FRAME_PIXELS (FRAME_PIXELS)
    ) u_wr_ptr (
        .clk        (clk),
        .reset      (reset),
        .inc        (w_wr_inc),
        .addr       (wr_addr),
        .wrap_pulse (wr_frame_done)
    );

    // Read wrap pulse lands on the same edge as out_valid, so they coincide.
    frame_addr_ctr #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .BASE_ADDR    (BASE_ADDR),
        .FRAME_PIXELS (FRAME_PIXELS)
    ) u_rd_ptr (
        .clk        (clk),
        .reset      (reset),
        .inc        (w_rd_inc),
        .addr       (rd_addr),
        .wrap_pulse (rd_frame_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_last_wr <= 1'b0;
            wr_en_n   <= DEASSERT_L;
            rd_en_n   <= DEASSERT_L;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            wr_data   <= '0;
            out_data  <= '0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_last_wr <= w_last_wr_next;
            wr_en_n   <= w_wr_en_n_next;
            rd_en_n   <= w_rd_en_n_next;
            in_ready  <= w_in_ready_next;
            out_valid <= w_out_valid_next;
            wr_data   <= w_wr_data_next;
            out_data  <= w_out_data_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_last_wr_next   = r_last_wr;
        w_wr_en_n_next   = wr_en_n;
        w_rd_en_n_next   = rd_en_n;
        w_in_ready_next  = 1'b0;
        w_out_valid_next = 1'b0;
        w_wr_data_next   = wr_data;
        w_out_data_next  = out_data;
        w_wr_inc         = 1'b0;
        w_rd_inc         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_cnt_next = '0;
                // A read wins only when the previous grant was a write.
                if (in_valid && (!r_last_wr || !rd_req)) begin
                    w_in_ready_next = 1'b1;
                    w_wr_data_next  = in_data;
                    w_wr_en_n_next  = ASSERT_L;
                    w_last_wr_next  = 1'b1;
                    w_state_next    = ST_WR;
                end else if (rd_req) begin
                    w_rd_en_n_next = ASSERT_L;
                    w_last_wr_next = 1'b0;
                    w_state_next   = ST_RD;
                end
            end
            ST_WR: begin
                if (r_cnt == CNT_W'(WR_HOLD - 1)) begin
                    w_wr_en_n_next = DEASSERT_L;
                    w_wr_inc       = 1'b1;
                    w_cnt_next     = '0;
                    w_state_next   = ST_GAP;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_RD: begin
                if (r_cnt == CNT_W'(RD_HOLD - 1)) begin
                    w_rd_en_n_next = DEASSERT_L;
                    w_cnt_next     = '0;
                    w_state_next   = ST_CAP;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_CAP: begin
                w_out_data_next  = rd_data;
                w_out_valid_next = 1'b1;
                w_rd_inc         = 1'b1;
                w_cnt_next       = '0;
                w_state_next     = ST_GAP;
            end
            ST_GAP: begin
                if (r_cnt == CNT_W'(IDLE_GAP - 1)) begin
                    w_cnt_next   = '0;
                    w_state_next = ST_IDLE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_wr_en_n_next = DEASSERT_L;
                w_rd_en_n_next = DEASSERT_L;
                w_cnt_next     = '0;
                w_state_next   = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_buf_mem_initiator.sv
`default_nettype none
// ============================================================================
// tb_frame_buf_mem_initiator : self-checking bench with a memory responder
// and a frame-address reference model.  Rev 1.0
// ============================================================================
module tb_frame_buf_mem_initiator;

    localparam int DW   = 32;
    localparam int AW   = 29;
    localparam int BASE = 1;
    localparam int FP   = 4;
    localparam int WRH  = 3;
    localparam int RDH  = 3;
    localparam int GAPC = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          rd_req = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          wr_frame_done;
    logic          rd_frame_done;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] wr_data;
    logic          wr_en_n;
    logic          rd_en_n;
    logic [DW-1:0] rd_data = '0;

    frame_buf_mem_initiator #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .BASE_ADDR    (AW'(BASE)),
        .FRAME_PIXELS (FP),
        .WR_HOLD      (WRH),
        .RD_HOLD      (RDH),
        .IDLE_GAP     (GAPC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .rd_req        (rd_req),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .wr_frame_done (wr_frame_done),
        .rd_frame_done (rd_frame_done),
        .wr_addr       (wr_addr),
        .rd_addr       (rd_addr),
        .wr_data       (wr_data),
        .wr_en_n       (wr_en_n),
        .rd_en_n       (rd_en_n),
        .rd_data       (rd_data)
    );

    always #5 clk = ~clk;

    // Memory responder
    logic [DW-1:0] tb_mem [0:15];
    always @(posedge clk) begin
        if (!wr_en_n) tb_mem[wr_addr[3:0]] <= wr_data;
        if (!rd_en_n) rd_data <= tb_mem[rd_addr[3:0]];
    end

    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; int len; } wrec_t;
    typedef struct { logic [AW-1:0] addr; int len; int first; } rrec_t;
    typedef struct { logic [DW-1:0] data; logic fd; int cyc; } orec_t;

    wrec_t   wr_q[$];
    rrec_t   rd_q[$];
    orec_t   ov_q[$];
    int      grant_q[$];
    int      wfd_q[$];
    logic [DW-1:0] tx_q[$];
    logic [DW-1:0] sent_q[$];
    logic [DW-1:0] model_mem [0:15];

    int checks = 0;
    int failures = 0;
    int ir_cnt = 0;
    int rfd_cnt = 0;
    int wr_done = 0;
    int cyc = 0;
    int wr_run = 0;
    int rd_run = 0;
    int gap = 99;
    wrec_t cur_w;
    rrec_t cur_r;
    orec_t cur_o;

    // Reference address of the k-th access in one direction since reset
    function automatic logic [AW-1:0] frame_addr(input int k);
        return AW'(BASE + (k % FP));
    endfunction

    // Protocol monitor
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            wr_run = 0;
            rd_run = 0;
            gap    = 99;
        end else begin
            checks++;
            if (!wr_en_n && !rd_en_n) begin
                failures++;
                $display("FAIL enables_exclusive: wr_en_n=0 rd_en_n=0 at cycle %0d, required at most one low", cyc);
            end
            if (in_ready) ir_cnt++;
            if (rd_frame_done) rfd_cnt++;
            if (!wr_en_n) begin
                if (wr_run == 0) begin
                    cur_w.addr = wr_addr;
                    cur_w.data = wr_data;
                    grant_q.push_back(1);
                    checks++;
                    if (gap < GAPC + 1) begin
                        failures++;
                        $display("FAIL idle_gap_wr: gap=%0d, required >=%0d", gap, GAPC + 1);
                    end
                end else begin
                    checks++;
                    if (wr_addr !== cur_w.addr || wr_data !== cur_w.data) begin
                        failures++;
                        $display("FAIL wr_stable: addr=%0h data=%0h, required addr=%0h data=%0h",
                                 wr_addr, wr_data, cur_w.addr, cur_w.data);
                    end
                end
                wr_run++;
            end else if (wr_run != 0) begin
                cur_w.len = wr_run;
                wr_q.push_back(cur_w);
                wr_run = 0;
                wr_done++;
            end
            if (!rd_en_n) begin
                if (rd_run == 0) begin
                    cur_r.addr  = rd_addr;
                    cur_r.first = cyc;
                    grant_q.push_back(0);
                    checks++;
                    if (gap < GAPC + 1) begin
                        failures++;
                        $display("FAIL idle_gap_rd: gap=%0d, required >=%0d", gap, GAPC + 1);
                    end
                end else begin
                    checks++;
                    if (rd_addr !== cur_r.addr) begin
                        failures++;
                        $display("FAIL rd_stable: addr=%0h, required %0h", rd_addr, cur_r.addr);
                    end
                end
                rd_run++;
            end else if (rd_run != 0) begin
                cur_r.len = rd_run;
                rd_q.push_back(cur_r);
                rd_run = 0;
            end
            if (wr_frame_done) wfd_q.push_back(wr_done);
            if (out_valid) begin
                cur_o.data = out_data;
                cur_o.fd   = rd_frame_done;
                cur_o.cyc  = cyc;
                ov_q.push_back(cur_o);
            end
            if (wr_en_n && rd_en_n) gap++;
            else gap = 0;
        end
    end

    task automatic do_reset();
        in_valid = 1'b0;
        rd_req   = 1'b0;
        reset    = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        wr_q.delete(); rd_q.delete(); ov_q.delete(); grant_q.delete();
        wfd_q.delete(); sent_q.delete(); tx_q.delete();
        ir_cnt = 0; rfd_cnt = 0; wr_done = 0;
    endtask

    task automatic drive_writes();
        int base;
        int guard;
        while (tx_q.size() > 0) begin
            in_data  = tx_q[0];
            in_valid = 1'b1;
            base     = ir_cnt;
            guard    = 0;
            while (ir_cnt == base && guard < 60) begin
                @(posedge clk); #1;
                guard++;
            end
            checks++;
            if (ir_cnt == base) begin
                failures++;
                $display("FAIL write_accept: in_ready not seen in 60 cycles, required a pulse");
                tx_q.delete();
            end else begin
                sent_q.push_back(tx_q.pop_front());
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_writes(input int n);
        int guard = 0;
        while (wr_q.size() < n && guard < 40 * n) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (wr_q.size() < n) begin
            failures++;
            $display("FAIL write_timeout: writes=%0d, required %0d", wr_q.size(), n);
        end
    endtask

    task automatic drive_reads(input int n);
        int guard = 0;
        rd_req = 1'b1;
        while (ov_q.size() < n && guard < 40 * n) begin
            @(posedge clk); #1;
            guard++;
        end
        rd_req = 1'b0;
        checks++;
        if (ov_q.size() < n) begin
            failures++;
            $display("FAIL read_timeout: out_valid count=%0d, required %0d", ov_q.size(), n);
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        in_valid = 1'b1;
        rd_req   = 1'b1;
        in_data  = $urandom;
        reset    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({wr_en_n, rd_en_n, in_ready, out_valid, wr_frame_done, rd_frame_done} !== 6'b110000) begin
            failures++;
            $display("FAIL reset_ctrl: {wr_en_n,rd_en_n,in_ready,out_valid,wfd,rfd}=%b, required 110000",
                     {wr_en_n, rd_en_n, in_ready, out_valid, wr_frame_done, rd_frame_done});
        end
        checks++;
        if (out_data !== '0 || wr_data !== '0) begin
            failures++;
            $display("FAIL reset_data: out_data=%0h wr_data=%0h, required 0 0", out_data, wr_data);
        end
        checks++;
        if (wr_addr !== AW'(BASE) || rd_addr !== AW'(BASE)) begin
            failures++;
            $display("FAIL reset_addr: wr_addr=%0h rd_addr=%0h, required %0h", wr_addr, rd_addr, BASE);
        end
        do_reset();
    endtask

    task automatic test_single_write();
        do_reset();
        tx_q.push_back(32'hA5A5_0001);
        drive_writes();
        wait_writes(1);
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (ir_cnt !== 1 || wr_q.size() !== 1 || rd_q.size() !== 0) begin
            failures++;
            $display("FAIL single_counts: in_ready=%0d writes=%0d reads=%0d, required 1 1 0",
                     ir_cnt, wr_q.size(), rd_q.size());
        end
        if (wr_q.size() > 0) begin
            checks++;
            if (wr_q[0].addr !== AW'(BASE) || wr_q[0].data !== 32'hA5A5_0001 || wr_q[0].len !== WRH) begin
                failures++;
                $display("FAIL single_write: addr=%0h data=%0h len=%0d, required %0h a5a50001 %0d",
                         wr_q[0].addr, wr_q[0].data, wr_q[0].len, BASE, WRH);
            end
            model_mem[BASE] = 32'hA5A5_0001;
        end
        checks++;
        if (wfd_q.size() !== 0 || wr_addr !== AW'(BASE + 1)) begin
            failures++;
            $display("FAIL single_ptr: wfd=%0d wr_addr=%0h, required 0 %0h", wfd_q.size(), wr_addr, BASE + 1);
        end
    endtask

    task automatic test_write_then_read();
        do_reset();
        for (int i = 0; i < 4; i++) tx_q.push_back(DW'(10 + i));
        drive_writes();
        wait_writes(4);
        for (int i = 0; i < wr_q.size(); i++) begin
            checks++;
            if (wr_q[i].addr !== frame_addr(i) || wr_q[i].data !== sent_q[i] || wr_q[i].len !== WRH) begin
                failures++;
                $display("FAIL wtr_write%0d: addr=%0h data=%0h len=%0d, required %0h %0h %0d",
                         i, wr_q[i].addr, wr_q[i].data, wr_q[i].len, frame_addr(i), sent_q[i], WRH);
            end
            model_mem[frame_addr(i)] = sent_q[i];
        end
        drive_reads(4);
        checks++;
        if (rd_q.size() !== 4) begin
            failures++;
            $display("FAIL wtr_read_count: reads=%0d, required 4", rd_q.size());
        end
        for (int i = 0; i < ov_q.size() && i < rd_q.size(); i++) begin
            checks++;
            if (rd_q[i].addr !== frame_addr(i) || rd_q[i].len !== RDH ||
                ov_q[i].data !== model_mem[frame_addr(i)] || ov_q[i].cyc - rd_q[i].first !== RDH + 1) begin
                failures++;
                $display("FAIL wtr_read%0d: addr=%0h len=%0d data=%0h lat=%0d, required %0h %0d %0h %0d",
                         i, rd_q[i].addr, rd_q[i].len, ov_q[i].data, ov_q[i].cyc - rd_q[i].first,
                         frame_addr(i), RDH, model_mem[frame_addr(i)], RDH + 1);
            end
        end
    endtask

    task automatic test_contention();
        do_reset();
        for (int i = 0; i < 4; i++) tx_q.push_back($urandom);
        rd_req = 1'b1;
        drive_writes();
        drive_reads(4);
        wait_writes(4);
        checks++;
        if (grant_q.size() !== 8) begin
            failures++;
            $display("FAIL cont_grants: grants=%0d, required 8", grant_q.size());
        end
        for (int i = 0; i < grant_q.size() && i < 8; i++) begin
            checks++;
            if (grant_q[i] !== ((i % 2 == 0) ? 1 : 0)) begin
                failures++;
                $display("FAIL cont_order%0d: write_grant=%0d, required %0d", i, grant_q[i], (i % 2 == 0) ? 1 : 0);
            end
        end
        for (int i = 0; i < sent_q.size(); i++) model_mem[frame_addr(i)] = sent_q[i];
        for (int i = 0; i < ov_q.size(); i++) begin
            checks++;
            if (ov_q[i].data !== model_mem[frame_addr(i)]) begin
                failures++;
                $display("FAIL cont_data%0d: out_data=%0h, required %0h", i, ov_q[i].data, model_mem[frame_addr(i)]);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 5; i++) tx_q.push_back($urandom);
        drive_writes();
        wait_writes(5);
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < wr_q.size(); i++) begin
            checks++;
            if (wr_q[i].addr !== frame_addr(i) || wr_q[i].data !== sent_q[i]) begin
                failures++;
                $display("FAIL wrap_write%0d: addr=%0h data=%0h, required %0h %0h",
                         i, wr_q[i].addr, wr_q[i].data, frame_addr(i), sent_q[i]);
            end
            model_mem[frame_addr(i)] = sent_q[i];
        end
        checks++;
        if (wfd_q.size() !== 1 || (wfd_q.size() > 0 && wfd_q[0] !== FP)) begin
            failures++;
            $display("FAIL wr_frame_done: pulses=%0d after_write=%0d, required 1 %0d",
                     wfd_q.size(), (wfd_q.size() > 0) ? wfd_q[0] : -1, FP);
        end
        drive_reads(4);
        for (int i = 0; i < ov_q.size(); i++) begin
            checks++;
            if (ov_q[i].data !== model_mem[frame_addr(i)] || ov_q[i].fd !== (i == FP - 1)) begin
                failures++;
                $display("FAIL rd_wrap%0d: data=%0h fd=%0b, required %0h %0b",
                         i, ov_q[i].data, ov_q[i].fd, model_mem[frame_addr(i)], (i == FP - 1));
            end
        end
        checks++;
        if (rfd_cnt !== 1 || rd_addr !== AW'(BASE)) begin
            failures++;
            $display("FAIL rd_frame_done: pulses=%0d rd_addr=%0h, required 1 %0h", rfd_cnt, rd_addr, BASE);
        end
    endtask

    task automatic test_reset_mid_read();
        int guard = 0;
        do_reset();
        rd_req = 1'b1;
        while (rd_en_n !== 1'b0 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        reset  = 1'b1;
        rd_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (rd_en_n !== 1'b1 || rd_addr !== AW'(BASE) || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: rd_en_n=%b rd_addr=%0h out_valid=%b, required 1 %0h 0",
                     rd_en_n, rd_addr, out_valid, BASE);
        end
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (ov_q.size() !== 0 || rd_q.size() !== 0) begin
            failures++;
            $display("FAIL mid_reset_quiet: out_valid=%0d reads=%0d, required 0 0", ov_q.size(), rd_q.size());
        end
        drive_reads(1);
        checks++;
        if (rd_q.size() !== 1 || ov_q.size() !== 1 ||
            rd_q[0].addr !== AW'(BASE) || ov_q[0].data !== model_mem[BASE]) begin
            failures++;
            $display("FAIL post_reset_read: reads=%0d addr=%0h data=%0h, required 1 %0h %0h",
                     rd_q.size(), (rd_q.size() > 0) ? rd_q[0].addr : '0,
                     (ov_q.size() > 0) ? ov_q[0].data : '0, BASE, model_mem[BASE]);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            tb_mem[i]    = '0;
            model_mem[i] = '0;
        end
        test_reset();
        test_single_write();
        test_write_then_read();
        test_contention();
        test_wrap();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
